mcpu_ctrl: RTL and testbench

Multi-cycle MIPS control unit for the MCPU core. A Moore state machine with a few Mealy-qualified write enables. It decodes the latched instruction's OP/Func fields and sequences fetch, decode, execute, memory and write-back. It drives every datapath select and enable, including the register-file write enable (`RegWrite` → regfile `L_S`) and the write-address/data selects that feed the regfile write port.

---
 rtl/mcpu_ctrl_pkg.sv | 94 +++++++++
 rtl/mcpu_alu_dec.sv | 51 +++++
 rtl/mcpu_ctrl.sv | 176 +++++++++++++++++
 tb/tb_mcpu_ctrl.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/mcpu_ctrl_pkg.sv
// rtl/mcpu_ctrl_pkg.sv - shared encodings for the MCPU multi-cycle control unit
package mcpu_ctrl_pkg;

  // Control states; the 4-bit code is also exported for debug display
  typedef enum logic [3:0] {
    S_IF  = 4'd0,
    S_ID  = 4'd1,
    S_MA  = 4'd2,
    S_MRD = 4'd3,
    S_WBM = 4'd4,
    S_MWR = 4'd5,
    S_EXR = 4'd6,
    S_WBR = 4'd7,
    S_BR  = 4'd8,
    S_J   = 4'd9,
    S_EXI = 4'd10,
    S_WBI = 4'd11,
    S_JAL = 4'd12,
    S_JR  = 4'd13,
    S_WBL = 4'd14
  } state_e;

  // Opcodes (instruction[31:26])
  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_BNE  = 6'b000101;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_JAL  = 6'b000011;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_ANDI = 6'b001100;
  localparam logic [5:0] OP_ORI  = 6'b001101;
  localparam logic [5:0] OP_SLTI = 6'b001010;
  localparam logic [5:0] OP_LUI  = 6'b001111;

  // R-type function codes (instruction[5:0])
  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_XOR = 6'b100110;
  localparam logic [5:0] FN_NOR = 6'b100111;
  localparam logic [5:0] FN_SLT = 6'b101010;
  localparam logic [5:0] FN_SRL = 6'b000010;
  localparam logic [5:0] FN_JR  = 6'b001000;

  // ALU operation codes
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_XOR = 3'b011;
  localparam logic [2:0] ALU_NOR = 3'b100;
  localparam logic [2:0] ALU_SRL = 3'b101;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  // Datapath select encodings
  localparam logic [1:0] PCS_ALU   = 2'b00;
  localparam logic [1:0] PCS_OUT   = 2'b01;
  localparam logic [1:0] PCS_JUMP  = 2'b10;
  localparam logic [1:0] PCS_RA    = 2'b11;

  localparam logic [1:0] SRCB_B    = 2'b00;
  localparam logic [1:0] SRCB_4    = 2'b01;
  localparam logic [1:0] SRCB_IMM  = 2'b10;
  localparam logic [1:0] SRCB_BOFS = 2'b11;

  localparam logic [1:0] RD_RT     = 2'b00;
  localparam logic [1:0] RD_RD     = 2'b01;
  localparam logic [1:0] RD_RA     = 2'b10;

  localparam logic [1:0] M2R_ALU   = 2'b00;
  localparam logic [1:0] M2R_MDR   = 2'b01;
  localparam logic [1:0] M2R_PC    = 2'b10;
  localparam logic [1:0] M2R_LUI   = 2'b11;

  // What kind of ALU operation the current state asks for
  localparam logic [2:0] CLS_NONE = 3'd0;
  localparam logic [2:0] CLS_ADD  = 3'd1;
  localparam logic [2:0] CLS_SUB  = 3'd2;
  localparam logic [2:0] CLS_FUNC = 3'd3;
  localparam logic [2:0] CLS_IMM  = 3'd4;

  // R-type ALU functions handled by EXR (jr is dispatched separately)
  function automatic logic is_alu_func(input logic [5:0] fn);
    case (fn)
      FN_ADD, FN_SUB, FN_AND, FN_OR, FN_XOR,
      FN_NOR, FN_SLT, FN_SRL: is_alu_func = 1'b1;
      default:                is_alu_func = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mcpu_alu_dec.sv
// rtl/mcpu_alu_dec.sv - ALU operation and immediate-extension decode
module mcpu_alu_dec
  import mcpu_ctrl_pkg::*;
(
  input  logic [2:0] alu_cls_i,
  input  logic [5:0] op_i,
  input  logic [5:0] func_i,
  output logic [2:0] alu_ctrl_o,
  output logic       imm_zext_o
);

  // Pick the ALU operation from the state class, then from Func or OP
  always_comb begin
    alu_ctrl_o = ALU_AND;
    imm_zext_o = 1'b0;
    case (alu_cls_i)
      CLS_ADD: alu_ctrl_o = ALU_ADD;
      CLS_SUB: alu_ctrl_o = ALU_SUB;
      CLS_FUNC: begin
        case (func_i)
          FN_ADD:  alu_ctrl_o = ALU_ADD;
          FN_SUB:  alu_ctrl_o = ALU_SUB;
          FN_AND:  alu_ctrl_o = ALU_AND;
          FN_OR:   alu_ctrl_o = ALU_OR;
          FN_XOR:  alu_ctrl_o = ALU_XOR;
          FN_NOR:  alu_ctrl_o = ALU_NOR;
          FN_SLT:  alu_ctrl_o = ALU_SLT;
          FN_SRL:  alu_ctrl_o = ALU_SRL;
          default: alu_ctrl_o = ALU_AND;
        endcase
      end
      CLS_IMM: begin
        case (op_i)
          OP_ADDI: alu_ctrl_o = ALU_ADD;
          OP_ANDI: begin
            alu_ctrl_o = ALU_AND;
            imm_zext_o = 1'b1;
          end
          OP_ORI: begin
            alu_ctrl_o = ALU_OR;
            imm_zext_o = 1'b1;
          end
          OP_SLTI: alu_ctrl_o = ALU_SLT;
          default: alu_ctrl_o = ALU_ADD;
        endcase
      end
      default: alu_ctrl_o = ALU_AND;
    endcase
  end

endmodule

// File: rtl/mcpu_ctrl.sv
// rtl/mcpu_ctrl.sv - multi-cycle MIPS control FSM with combinational output decode
module mcpu_ctrl
  import mcpu_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] OP,
  input  logic [5:0] Func,
  input  logic       zero,
  input  logic       MIO_ready,
  output logic [3:0] state,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IorD,
  output logic       IRWrite,
  output logic       PCWrite,
  output logic [1:0] PCSource,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic       ImmZext,
  output logic [2:0] ALU_Control,
  output logic       RegWrite,
  output logic [1:0] RegDst,
  output logic [1:0] MemtoReg
);

  state_e     state_q;
  state_e     state_d;
  logic [2:0] alu_cls;
  logic       mem_write_c;
  logic       ir_write_c;
  logic       pc_write_c;
  logic       reg_write_c;

  // State register; reset returns to fetch without waiting for a clock
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IF;
    else     state_q <= state_d;
  end

  // Next-state: fetch/memory states hold on MIO_ready, ID dispatches on OP/Func
  always_comb begin
    state_d = S_IF;
    case (state_q)
      S_IF:  state_d = MIO_ready ? S_ID : S_IF;
      S_ID: begin
        case (OP)
          OP_R: begin
            if (Func == FN_JR)         state_d = S_JR;
            else if (is_alu_func(Func)) state_d = S_EXR;
            else                        state_d = S_IF;
          end
          OP_LW, OP_SW:                      state_d = S_MA;
          OP_BEQ, OP_BNE:                    state_d = S_BR;
          OP_J:                              state_d = S_J;
          OP_JAL:                            state_d = S_JAL;
          OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI: state_d = S_EXI;
          OP_LUI:                            state_d = S_WBL;
          default:                           state_d = S_IF;
        endcase
      end
      S_MA: begin
        if (OP == OP_LW)      state_d = S_MRD;
        else if (OP == OP_SW) state_d = S_MWR;
        else                  state_d = S_IF;
      end
      S_MRD: state_d = MIO_ready ? S_WBM : S_MRD;
      S_MWR: state_d = MIO_ready ? S_IF : S_MWR;
      S_EXR: state_d = S_WBR;
      S_EXI: state_d = S_WBI;
      default: state_d = S_IF;
    endcase
  end

  // Moore output decode, with IRWrite/PCWrite qualified by ready or branch outcome
  always_comb begin
    MemRead     = 1'b0;
    mem_write_c = 1'b0;
    IorD        = 1'b0;
    ir_write_c  = 1'b0;
    pc_write_c  = 1'b0;
    PCSource    = PCS_ALU;
    ALUSrcA     = 1'b0;
    ALUSrcB     = SRCB_B;
    alu_cls     = CLS_NONE;
    reg_write_c = 1'b0;
    RegDst      = RD_RT;
    MemtoReg    = M2R_ALU;
    case (state_q)
      S_IF: begin
        MemRead    = 1'b1;
        ALUSrcB    = SRCB_4;
        alu_cls    = CLS_ADD;
        ir_write_c = MIO_ready;
        pc_write_c = MIO_ready;
      end
      S_ID: begin
        ALUSrcB = SRCB_BOFS;
        alu_cls = CLS_ADD;
      end
      S_MA: begin
        ALUSrcA = 1'b1;
        ALUSrcB = SRCB_IMM;
        alu_cls = CLS_ADD;
      end
      S_MRD: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
      end
      S_WBM: begin
        reg_write_c = 1'b1;
        MemtoReg    = M2R_MDR;
      end
      S_MWR: begin
        mem_write_c = 1'b1;
        IorD        = 1'b1;
      end
      S_EXR: begin
        ALUSrcA = 1'b1;
        alu_cls = CLS_FUNC;
      end
      S_WBR: begin
        reg_write_c = 1'b1;
        RegDst      = RD_RD;
      end
      S_BR: begin
        ALUSrcA    = 1'b1;
        alu_cls    = CLS_SUB;
        PCSource   = PCS_OUT;
        pc_write_c = (OP == OP_BEQ) ? zero : ~zero;
      end
      S_J: begin
        PCSource   = PCS_JUMP;
        pc_write_c = 1'b1;
      end
      S_EXI: begin
        ALUSrcA = 1'b1;
        ALUSrcB = SRCB_IMM;
        alu_cls = CLS_IMM;
      end
      S_WBI: reg_write_c = 1'b1;
      S_JAL: begin
        reg_write_c = 1'b1;
        RegDst      = RD_RA;
        MemtoReg    = M2R_PC;
        PCSource    = PCS_JUMP;
        pc_write_c  = 1'b1;
      end
      S_JR: begin
        PCSource   = PCS_RA;
        pc_write_c = 1'b1;
      end
      S_WBL: begin
        reg_write_c = 1'b1;
        MemtoReg    = M2R_LUI;
      end
      default: ;
    endcase
  end

  mcpu_alu_dec u_alu_dec (
    .alu_cls_i  (alu_cls),
    .op_i       (OP),
    .func_i     (Func),
    .alu_ctrl_o (ALU_Control),
    .imm_zext_o (ImmZext)
  );

  // Architectural write enables are held off for the whole reset pulse
  assign RegWrite = reg_write_c & ~rst;
  assign MemWrite = mem_write_c & ~rst;
  assign PCWrite  = pc_write_c  & ~rst;
  assign IRWrite  = ir_write_c  & ~rst;
  assign state    = state_q;

endmodule

// File: tb/tb_mcpu_ctrl.sv
// tb/tb_mcpu_ctrl.sv - randomized self-checking bench for mcpu_ctrl
module tb_mcpu_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] OP;
  logic [5:0] Func;
  logic       zero;
  logic       MIO_ready;
  logic [3:0] state;
  logic       MemRead, MemWrite, IorD, IRWrite, PCWrite;
  logic [1:0] PCSource;
  logic       ALUSrcA;
  logic [1:0] ALUSrcB;
  logic       ImmZext;
  logic [2:0] ALU_Control;
  logic       RegWrite;
  logic [1:0] RegDst;
  logic [1:0] MemtoReg;

  int total = 0;
  int bad   = 0;

  mcpu_ctrl dut (
    .clk(clk), .rst(rst), .OP(OP), .Func(Func), .zero(zero), .MIO_ready(MIO_ready),
    .state(state), .MemRead(MemRead), .MemWrite(MemWrite), .IorD(IorD),
    .IRWrite(IRWrite), .PCWrite(PCWrite), .PCSource(PCSource), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .ImmZext(ImmZext), .ALU_Control(ALU_Control),
    .RegWrite(RegWrite), .RegDst(RegDst), .MemtoReg(MemtoReg)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Instruction families as the ISA describes them
  typedef enum int {K_R, K_JR, K_LW, K_SW, K_BEQ, K_BNE, K_J, K_JAL, K_ALUI, K_LUI, K_BAD} kind_e;

  function automatic kind_e kind_of(input logic [5:0] op, input logic [5:0] fn);
    case (op)
      6'b000000: begin
        if (fn == 6'b001000) return K_JR;
        case (fn)
          6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b100110,
          6'b100111, 6'b101010, 6'b000010: return K_R;
          default: return K_BAD;
        endcase
      end
      6'b100011: return K_LW;
      6'b101011: return K_SW;
      6'b000100: return K_BEQ;
      6'b000101: return K_BNE;
      6'b000010: return K_J;
      6'b000011: return K_JAL;
      6'b001000, 6'b001100, 6'b001101, 6'b001010: return K_ALUI;
      6'b001111: return K_LUI;
      default: return K_BAD;
    endcase
  endfunction

  function automatic logic [2:0] alu_of_func(input logic [5:0] fn);
    case (fn)
      6'b100000: return 3'b010;
      6'b100010: return 3'b110;
      6'b100100: return 3'b000;
      6'b100101: return 3'b001;
      6'b100110: return 3'b011;
      6'b100111: return 3'b100;
      6'b101010: return 3'b111;
      6'b000010: return 3'b101;
      default:   return 3'b000;
    endcase
  endfunction

  // Expected outputs for one cycle of a state, packed in a fixed field order
  function automatic logic [18:0] exp_outs(input int code, input logic [5:0] op, input logic [5:0] fn,
                                           input logic z, input logic rdy);
    logic mr = 0, mw = 0, iod = 0, irw = 0, pcw = 0, asa = 0, zx = 0, rw = 0;
    logic [1:0] pcs = 0, asb = 0, rd = 0, m2r = 0;
    logic [2:0] alu = 0;
    case (code)
      0:  begin mr = 1; asb = 2'b01; alu = 3'b010; irw = rdy; pcw = rdy; end
      1:  begin asb = 2'b11; alu = 3'b010; end
      2:  begin asa = 1; asb = 2'b10; alu = 3'b010; end
      3:  begin mr = 1; iod = 1; end
      4:  begin rw = 1; m2r = 2'b01; end
      5:  begin mw = 1; iod = 1; end
      6:  begin asa = 1; alu = alu_of_func(fn); end
      7:  begin rw = 1; rd = 2'b01; end
      8:  begin asa = 1; alu = 3'b110; pcs = 2'b01; pcw = (op == 6'b000100) ? z : !z; end
      9:  begin pcs = 2'b10; pcw = 1; end
      10: begin
        asa = 1; asb = 2'b10;
        case (op)
          6'b001000: alu = 3'b010;
          6'b001100: begin alu = 3'b000; zx = 1; end
          6'b001101: begin alu = 3'b001; zx = 1; end
          default:   alu = 3'b111;
        endcase
      end
      11: rw = 1;
      12: begin rw = 1; rd = 2'b10; m2r = 2'b10; pcs = 2'b10; pcw = 1; end
      13: begin pcs = 2'b11; pcw = 1; end
      14: begin rw = 1; m2r = 2'b11; end
      default: ;
    endcase
    return {mr, mw, iod, irw, pcw, pcs, asa, asb, zx, alu, rw, rd, m2r};
  endfunction

  function automatic logic [18:0] dut_outs();
    return {MemRead, MemWrite, IorD, IRWrite, PCWrite, PCSource, ALUSrcA, ALUSrcB,
            ImmZext, ALU_Control, RegWrite, RegDst, MemtoReg};
  endfunction

  // Runs one instruction from IF; mem_waits<0 means random ready, else exact wait count
  // in MRD/MWR with IF ready at once. zmode 0/1 forces zero, 2 randomizes it.
  // stop_at>=0 returns right after checking that state (for the reset test).
  task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input int mem_waits,
                           input int zmode, input int stop_at);
    int path[$];
    kind_e k = kind_of(op, fn);
    path = '{0, 1};
    case (k)
      K_R:    path = '{0, 1, 6, 7};
      K_JR:   path = '{0, 1, 13};
      K_LW:   path = '{0, 1, 2, 3, 4};
      K_SW:   path = '{0, 1, 2, 5};
      K_BEQ, K_BNE: path = '{0, 1, 8};
      K_J:    path = '{0, 1, 9};
      K_JAL:  path = '{0, 1, 12};
      K_ALUI: path = '{0, 1, 10, 11};
      K_LUI:  path = '{0, 1, 14};
      default: ;
    endcase
    foreach (path[i]) begin
      int code = path[i];
      int waited = 0;
      logic is_wait = (code == 0 || code == 3 || code == 5);
      forever begin
        @(negedge clk);
        OP = op; Func = fn;
        zero = (zmode == 2) ? 1'($urandom % 2) : 1'(zmode);
        if (!is_wait)            MIO_ready = 1'($urandom % 2);
        else if (mem_waits >= 0) MIO_ready = (code == 0) ? 1'b1 : (waited >= mem_waits);
        else                     MIO_ready = (waited >= 3) ? 1'b1 : ($urandom % 4 != 0);
        #1;
        check($sformatf("state op=%h fn=%h step=%0d", op, fn, i), 32'(state), 32'(code));
        check($sformatf("outs st=%0d op=%h fn=%h", code, op, fn), 32'(dut_outs()),
              32'(exp_outs(code, op, fn, zero, MIO_ready)));
        if (code == stop_at) return;
        if (!(is_wait && !MIO_ready)) break;
        waited++;
      end
    end
  endtask

  logic [5:0] ops [13] = '{6'h00, 6'h23, 6'h2b, 6'h04, 6'h05, 6'h02, 6'h03,
                           6'h08, 6'h0c, 6'h0d, 6'h0a, 6'h0f, 6'h3f};
  logic [5:0] fns [9]  = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2a, 6'h02, 6'h08};

  initial begin
    rst = 1'b1; OP = 6'h0; Func = 6'h0; zero = 1'b0; MIO_ready = 1'b1;
    #1;
    check("rst_state", 32'(state), 32'd0);
    check("rst_outs", 32'(dut_outs()), 32'(exp_outs(0, 6'h0, 6'h0, 1'b0, 1'b0)));
    @(negedge clk); @(negedge clk);
    rst = 1'b0; MIO_ready = 1'b0;
    #1;
    check("post_rst_idle_irw", 32'(IRWrite), 32'd0);

    // Directed cases
    run_instr(6'h00, 6'h20, 0, 2, -1);   // add
    run_instr(6'h23, 6'h00, 2, 2, -1);   // lw with two MRD waits
    run_instr(6'h2b, 6'h00, 1, 2, -1);   // sw with one MWR wait
    run_instr(6'h04, 6'h00, 0, 1, -1);   // beq taken
    run_instr(6'h05, 6'h00, 0, 1, -1);   // bne not taken
    run_instr(6'h05, 6'h00, 0, 0, -1);   // bne taken
    run_instr(6'h03, 6'h00, 0, 2, -1);   // jal
    run_instr(6'h3f, 6'h00, 0, 2, -1);   // undefined op
    run_instr(6'h00, 6'h3f, 0, 2, -1);   // undefined func
    run_instr(6'h0f, 6'h00, 0, 2, -1);   // lui

    // Asynchronous reset in WBR of an add
    run_instr(6'h00, 6'h20, 0, 2, 7);
    #1; MIO_ready = 1'b1; rst = 1'b1;
    #1;
    check("midrst_state", 32'(state), 32'd0);
    check("midrst_regwrite", 32'(RegWrite), 32'd0);
    check("midrst_outs", 32'(dut_outs()), 32'(exp_outs(0, 6'h0, 6'h20, zero, 1'b0)));
    @(negedge clk);
    rst = 1'b0; MIO_ready = 1'b1;
    #1;
    check("rel_irwrite", 32'(IRWrite), 32'd1);
    check("rel_state", 32'(state), 32'd0);
    #1; MIO_ready = 1'b0;

    // Random instruction stream
    for (int n = 0; n < 300; n++) begin
      logic [5:0] op = ops[$urandom_range(0, 12)];
      logic [5:0] fn = ($urandom % 8 == 0) ? 6'($urandom) : fns[$urandom_range(0, 8)];
      if ($urandom % 10 == 0) op = 6'($urandom);
      run_instr(op, fn, -1, 2, -1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
